seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_pkg.sv | 66 ++++++
 rtl/seq_detect_param_sat_counter.sv | 29 ++
 rtl/seq_detect_param.sv | 77 +++++++
 tb/tb_seq_detect_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared helpers for the parameterised serial pattern detector: width functions
// and elaboration-time KMP failure / next-state table construction.
package seq_detect_pkg;

    localparam int unsigned MAX_PAT_W = 16;
    localparam int unsigned TBL_W     = 5;   // holds prefix lengths 0..MAX_PAT_W
    localparam int unsigned IDX_W     = 4;   // indexes states 0..MAX_PAT_W-1

    typedef logic [MAX_PAT_W:0][TBL_W-1:0]        fail_tbl_t;
    typedef logic [MAX_PAT_W-1:0][1:0][TBL_W-1:0] next_tbl_t;

    typedef struct packed {
        fail_tbl_t fail;
        next_tbl_t nxt;
    } kmp_tbl_t;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_ADVANCE,
        STEP_MATCH
    } step_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned state_width(input int unsigned pat_w);
        return clog2(pat_w + 1);
    endfunction

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pbit(input logic [MAX_PAT_W-1:0] p,
                                  input int unsigned w, input int unsigned i);
        return p[IDX_W'(w - 1 - i)];
    endfunction

    function automatic kmp_tbl_t kmp_tables(input logic [MAX_PAT_W-1:0] pattern,
                                            input int unsigned pat_w);
        kmp_tbl_t    t;
        int unsigned k;
        t = '0;
        // fail[q] = longest proper border of the first q pattern bits
        for (int unsigned q = 1; q < pat_w; q++) begin
            k = 32'(t.fail[TBL_W'(q)]);
            while (k > 0 && pbit(pattern, pat_w, k) != pbit(pattern, pat_w, q))
                k = 32'(t.fail[TBL_W'(k)]);
            if (pbit(pattern, pat_w, k) == pbit(pattern, pat_w, q)) k = k + 1;
            t.fail[TBL_W'(q + 1)] = TBL_W'(k);
        end
        // nxt[s][b] may equal pat_w, which the caller treats as a match
        for (int unsigned s = 0; s < pat_w; s++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                k = s;
                while (k > 0 && pbit(pattern, pat_w, k) != 1'(b))
                    k = 32'(t.fail[TBL_W'(k)]);
                if (pbit(pattern, pat_w, k) == 1'(b)) k = k + 1;
                t.nxt[IDX_W'(s)][1'(b)] = TBL_W'(k);
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating match counter; a clear coinciding with an increment yields 1.
module sat_counter
    import seq_detect_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector driven by an elaboration-time KMP table, with a
// registered match pulse and a saturating match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned             PAT_W   = 4,
    parameter logic [PAT_W-1:0]        PATTERN = 4'b1011,
    parameter int unsigned             OVERLAP = 1,
    parameter int unsigned             CNT_W   = 8,
    localparam int unsigned            SW      = state_width(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic             in_valid,
    input  logic             clr_cnt,
    output logic             out,
    output logic [SW-1:0]    outputState,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam kmp_tbl_t TBL = kmp_tables(MAX_PAT_W'(PATTERN), PAT_W);
    localparam logic [SW-1:0] MATCH_RELOAD =
        (OVERLAP != 0) ? SW'(TBL.fail[TBL_W'(PAT_W)]) : '0;

    logic [SW-1:0]    state;
    logic [SW-1:0]    state_nxt;
    logic             out_nxt;
    logic [TBL_W-1:0] k;
    step_e            step;

    // State register and match pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
            out   <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
        end
    end

    // Table lookup; a full-length prefix is a match and reloads the border
    always_comb begin
        state_nxt = state;
        out_nxt   = 1'b0;
        k         = '0;
        step      = STEP_HOLD;
        if (in_valid) begin
            k    = TBL.nxt[IDX_W'(state)][inp];
            step = (k == TBL_W'(PAT_W)) ? STEP_MATCH : STEP_ADVANCE;
        end
        case (step)
            STEP_MATCH: begin
                out_nxt   = 1'b1;
                state_nxt = MATCH_RELOAD;
            end
            STEP_ADVANCE: state_nxt = SW'(k);
            default:      state_nxt = state;
        endcase
    end

    assign outputState = state;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_nxt),
        .clr (clr_cnt),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param across four parameterisations sharing one stimulus stream.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inp = 1'b0;
    logic in_valid = 1'b0;
    logic clr_cnt = 1'b0;

    always #5 clk = ~clk;

    // A: defaults (1011, overlap); B: no overlap; C: CNT_W=2; D: 111, PAT_W=3
    logic       a_out, b_out, c_out, d_out;
    logic [2:0] a_st, b_st, c_st;
    logic [1:0] d_st;
    logic [7:0] a_cnt, b_cnt, d_cnt;
    logic [1:0] c_cnt;
    logic       a_sat, b_sat, c_sat, d_sat;

    seq_detect_param u_a (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .out(a_out), .outputState(a_st), .match_cnt(a_cnt), .cnt_sat(a_sat));

    seq_detect_param #(.OVERLAP(0)) u_b (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .out(b_out), .outputState(b_st), .match_cnt(b_cnt), .cnt_sat(b_sat));

    seq_detect_param #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .out(c_out), .outputState(c_st), .match_cnt(c_cnt), .cnt_sat(c_sat));

    seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1)) u_d (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .clr_cnt(clr_cnt),
        .out(d_out), .outputState(d_st), .match_cnt(d_cnt), .cnt_sat(d_sat));

    typedef struct {
        string tag;
        int    id;
        logic  o;
        int    st;
        int    cnt;
        logic  sat;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int p1_bits [7] = '{1, 0, 1, 1, 0, 1, 1};
    int p1_a_st [7] = '{1, 2, 3, 1, 2, 3, 1};
    int p1_a_o  [7] = '{0, 0, 0, 1, 0, 0, 1};
    int p1_a_cnt[7] = '{0, 0, 0, 1, 1, 1, 2};
    int p1_b_st [7] = '{1, 2, 3, 0, 0, 1, 1};
    int p1_b_o  [7] = '{0, 0, 0, 1, 0, 0, 0};
    int p1_b_cnt[7] = '{0, 0, 0, 1, 1, 1, 1};

    function automatic void compare(input exp_t e);
        logic o, s;
        int   st, cnt;
        case (e.id)
            0:       begin o = a_out; st = 32'(a_st); cnt = 32'(a_cnt); s = a_sat; end
            1:       begin o = b_out; st = 32'(b_st); cnt = 32'(b_cnt); s = b_sat; end
            2:       begin o = c_out; st = 32'(c_st); cnt = 32'(c_cnt); s = c_sat; end
            default: begin o = d_out; st = 32'(d_st); cnt = 32'(d_cnt); s = d_sat; end
        endcase
        vectors++;
        if (o !== e.o || st != e.st || cnt != e.cnt || s !== e.sat) begin
            miscompares++;
            $display("FAIL %s dut%0d: got out=%0b state=%0d cnt=%0d sat=%0b, want out=%0b state=%0d cnt=%0d sat=%0b",
                     e.tag, e.id, o, st, cnt, s, e.o, e.st, e.cnt, e.sat);
        end
    endfunction

    function automatic void expect_(input string tag, input int id, input logic o,
                                    input int st, input int cnt, input logic sat);
        exp_t e;
        e.tag = tag; e.id = id; e.o = o; e.st = st; e.cnt = cnt; e.sat = sat;
        q.push_back(e);
    endfunction

    task automatic step(input logic v, input logic b, input logic clr);
        @(negedge clk);
        in_valid = v;
        inp      = b;
        clr_cnt  = clr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; inp = 1'b0; clr_cnt = 1'b0;
        for (int i = 0; i < 4; i++) expect_("reset", i, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every output cycle drains the expectations queued for it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                compare(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        exp_t e;

        // Overlap vs non-overlap on 1,0,1,1,0,1,1
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'(p1_bits[i]), 1'b0);
            expect_("ovl_stream", 0, 1'(p1_a_o[i]), p1_a_st[i], p1_a_cnt[i], 1'b0);
            expect_("novl_stream", 1, 1'(p1_b_o[i]), p1_b_st[i], p1_b_cnt[i], 1'b0);
        end

        // Invalid gap holds state and suppresses out
        do_reset();
        step(1'b1, 1'b1, 1'b0); expect_("gap_pre", 0, 1'b0, 1, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0); expect_("gap_pre", 0, 1'b0, 2, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0); expect_("gap_pre", 0, 1'b0, 3, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            expect_("gap_hold", 0, 1'b0, 3, 0, 1'b0);
            expect_("gap_hold", 1, 1'b0, 3, 0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        expect_("gap_match", 0, 1'b1, 1, 1, 1'b0);
        expect_("gap_match", 1, 1'b1, 0, 1, 1'b0);
        step(1'b0, 1'b0, 1'b0); expect_("pulse_width", 0, 1'b0, 1, 1, 1'b0);

        // Asynchronous reset mid-pattern
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'(p1_bits[i]), 1'b0);
            expect_("pre_rst", 0, 1'(p1_a_o[i]), p1_a_st[i], p1_a_cnt[i], 1'b0);
        end
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        e.tag = "async_rst"; e.id = 0; e.o = 1'b0; e.st = 0; e.cnt = 0; e.sat = 1'b0;
        compare(e);
        @(posedge clk);
        #1;
        e.tag = "rst_hold";
        compare(e);
        #2;
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0); expect_("post_rst", 0, 1'b0, 1, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0); expect_("post_rst", 0, 1'b0, 1, 0, 1'b0);

        // Saturation at CNT_W=2, then clear with and without a coincident match
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'(p1_bits[i]), 1'b0);
            expect_("sat_head", 2, 1'(p1_a_o[i]), p1_a_st[i], p1_a_cnt[i], 1'b0);
        end
        for (int r = 1; r <= 4; r++) begin
            int c0, c1;
            c0 = (r < 3) ? r : 3;
            c1 = (r + 1 < 3) ? r + 1 : 3;
            step(1'b1, 1'b0, 1'b0); expect_("sat_run", 2, 1'b0, 2, c0, 1'(c0 == 3));
            step(1'b1, 1'b1, 1'b0); expect_("sat_run", 2, 1'b0, 3, c0, 1'(c0 == 3));
            step(1'b1, 1'b1, 1'b0); expect_("sat_run", 2, 1'b1, 1, c1, 1'(c1 == 3));
        end
        step(1'b1, 1'b0, 1'b0); expect_("sat_hold", 2, 1'b0, 2, 3, 1'b1);
        step(1'b1, 1'b1, 1'b0); expect_("sat_hold", 2, 1'b0, 3, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1); expect_("clr_match", 2, 1'b1, 1, 1, 1'b0);
        step(1'b0, 1'b0, 1'b1); expect_("clr_alone", 2, 1'b0, 1, 0, 1'b0);

        // All-ones pattern with overlap fires on every bit from the third
        do_reset();
        step(1'b1, 1'b1, 1'b0); expect_("ones", 3, 1'b0, 1, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0); expect_("ones", 3, 1'b0, 2, 0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0); expect_("ones_match", 3, 1'b1, 2, i, 1'b0);
        end
        step(1'b1, 1'b0, 1'b0); expect_("ones_break", 3, 1'b0, 0, 4, 1'b0);

        step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
